// File: rtl/div_seq_n.sv
// div_seq_n: sequential restoring divider, one quotient bit per clock,
// with its own start/done FSM, divide-by-zero flag and registered results.
// Ports: clk, rst (async active-low), start, dividend, divisor -> busy,
// done (1-cycle pulse), quotient, remainder, div_by_zero.
// Optional macro SIGNED_DIV_EN: two's complement operands, truncating divide.
module div_seq_n #(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a, dv, b;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   as_w;
  logic [WIDTH-1:0] dvs;
  logic             fits;
  logic [WIDTH-1:0] a_nx, dv_nx;
  logic [WIDTH-1:0] q_fin, r_fin;
  logic             last;
  logic             dvs_zero;

`ifdef SIGNED_DIV_EN
  logic qs, rs;

  assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign q_fin   = qs ? -dv_nx : dv_nx;
  assign r_fin   = rs ? -a_nx  : a_nx;
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign q_fin   = dv_nx;
  assign r_fin   = a_nx;
`endif

  assign dvs_zero = (divisor == '0);
  assign last     = (cnt == CNT_W'(1));

  // The shifted partial remainder keeps its carry bit so divisors
  // above 2^(WIDTH-1) stay exact; the difference always fits WIDTH bits.
  assign as_w  = {a, dv[WIDTH-1]};
  assign dvs   = {dv[WIDTH-2:0], 1'b0};
  assign fits  = (as_w >= {1'b0, b});
  assign a_nx  = fits ? (as_w[WIDTH-1:0] - b) : as_w[WIDTH-1:0];
  assign dv_nx = fits ? {dvs[WIDTH-1:1], 1'b1} : dvs;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = dvs_zero ? DONE : RUN;
      RUN:  if (last)  state_nx = DONE;
      DONE:            state_nx = IDLE;
      default:         state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a           <= '0;
      dv          <= '0;
      b           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
      qs          <= 1'b0;
      rs          <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (dvs_zero) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              a           <= '0;
              dv          <= dvd_mag;
              b           <= dvs_mag;
              cnt         <= CNT_W'(WIDTH);
              div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
              qs <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              rs <= dividend[WIDTH-1];
`endif
            end
          end
        end
        RUN: begin
          a   <= a_nx;
          dv  <= dv_nx;
          cnt <= cnt - CNT_W'(1);
          if (last) begin
            quotient  <= q_fin;
            remainder <= r_fin;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_n.sv
// tb_div_seq_n: self-checking bench for div_seq_n (WIDTH=16) using a
// plain-arithmetic reference model and randomized operands.
module tb_div_seq_n;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, dbz;
  logic [W-1:0] quotient, remainder;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  div_seq_n #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(dbz)
  );

  function automatic void model(
    input  logic [W-1:0] a, b,
    output logic [W-1:0] q, r,
    output logic         z);
    logic [W-1:0] min_v;
    min_v = {1'b1, {(W-1){1'b0}}};
    if (b == '0) begin
      q = '1; r = a; z = 1'b1;
    end else begin
      z = 1'b0;
`ifdef SIGNED_DIV_EN
      if (a == min_v && b == '1) begin
        q = min_v; r = '0;
      end else begin
        q = W'($signed(a) / $signed(b));
        r = W'($signed(a) % $signed(b));
      end
`else
      q = a / b;
      r = a % b;
      if (min_v == '0) q = '0;
`endif
    end
  endfunction

  // Issue one division from IDLE and wait (bounded) for done.
  // lat counts edges from the accepting edge (=1); -1 on timeout.
  task automatic do_div(
    input  logic [W-1:0] a, b,
    output logic [W-1:0] q, r,
    output logic         z,
    output int           lat);
    @(negedge clk);
    for (int i = 0; busy && i < 40; i++) @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
    q = quotient; r = remainder; z = dbz;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, dbz} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b dbz=%b q=%h r=%h, want all 0",
               busy, done, dbz, quotient, remainder);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic;
    int lat;
    @(negedge clk);
    dividend = 16'd100; divisor = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: busy=%b done=%b, want 1 0", busy, done);
    end
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 17 || done !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: got %0d, want 17", lat);
    end
    checks++;
    if (quotient !== 16'd14 || remainder !== 16'd2 || dbz !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: q=%0d r=%0d z=%b, want 14 2 0",
               quotient, remainder, dbz);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b busy=%b one cycle later, want 0 0",
               done, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (quotient !== 16'd14 || remainder !== 16'd2) begin
      errors++;
      $display("FAIL result_hold: q=%0d r=%0d, want 14 2", quotient, remainder);
    end
  endtask

  task automatic test_edges;
    logic [W-1:0] q, r;
    logic z;
    int lat;
    do_div(16'hFFFF, 16'h0001, q, r, z, lat);
    checks++;
    if (q !== 16'hFFFF || r !== 16'h0 || z !== 1'b0 || lat !== 17) begin
      errors++;
      $display("FAIL max_by_1: q=%h r=%h z=%b lat=%0d, want ffff 0 0 17",
               q, r, z, lat);
    end
    do_div(16'h0003, 16'hFFFF, q, r, z, lat);
    checks++;
    if (q !== 16'h0 || r !== 16'h3 || z !== 1'b0 || lat !== 17) begin
      errors++;
      $display("FAIL small_by_max: q=%h r=%h z=%b lat=%0d, want 0 3 0 17",
               q, r, z, lat);
    end
  endtask

  task automatic test_div_zero;
    logic [W-1:0] q, r;
    logic z;
    int lat;
    do_div(16'd5, 16'd0, q, r, z, lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL dz_latency: got %0d, want 1", lat);
    end
    checks++;
    if (q !== 16'hFFFF || r !== 16'd5 || z !== 1'b1) begin
      errors++;
      $display("FAIL dz_result: q=%h r=%0d z=%b, want ffff 5 1", q, r, z);
    end
    do_div(16'd9, 16'd3, q, r, z, lat);
    checks++;
    if (q !== 16'd3 || r !== 16'd0 || z !== 1'b0 || lat !== 17) begin
      errors++;
      $display("FAIL dz_clear: q=%0d r=%0d z=%b lat=%0d, want 3 0 0 17",
               q, r, z, lat);
    end
  endtask

  task automatic test_ignore_start;
    int n;
    int early;
    @(negedge clk);
    for (int i = 0; busy && i < 40; i++) @(negedge clk);
    dividend = 16'd100; divisor = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    early = 0;
    while (!done && n < 40) begin
      if (n == 5) begin
        start = 1'b1; dividend = 16'd50; divisor = 16'd5;
      end else if (n == 6) begin
        start = 1'b0; dividend = 16'd1234; divisor = 16'd3;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    checks++;
    if (n !== 17 || done !== 1'b1) begin
      errors++;
      $display("FAIL busy_start_latency: got %0d, want 17", n);
    end
    checks++;
    if (quotient !== 16'd14 || remainder !== 16'd2) begin
      errors++;
      $display("FAIL busy_start_result: q=%0d r=%0d, want 14 2",
               quotient, remainder);
    end
    if (early != 0) errors++;
  endtask

  task automatic test_back_to_back;
    int first, second;
    @(negedge clk);
    for (int i = 0; busy && i < 40; i++) @(negedge clk);
    dividend = 16'd100; divisor = 16'd7; start = 1'b1;
    first = -1; second = -1;
    for (int n = 1; n <= 60 && second < 0; n++) begin
      @(posedge clk); #1;
      if (done) begin
        if (first < 0) first = n;
        else second = n;
      end
    end
    start = 1'b0;
    checks++;
    if (first !== 17 || second - first !== 18) begin
      errors++;
      $display("FAIL back_to_back: first=%0d gap=%0d, want 17 18",
               first, second - first);
    end
    checks++;
    if (quotient !== 16'd14 || remainder !== 16'd2) begin
      errors++;
      $display("FAIL back_to_back_result: q=%0d r=%0d, want 14 2",
               quotient, remainder);
    end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] q, r;
    logic z;
    int lat;
    int pulses;
    @(negedge clk);
    for (int i = 0; busy && i < 40; i++) @(negedge clk);
    dividend = 16'd100; divisor = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, dbz} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b dbz=%b q=%h r=%h, want all 0",
               busy, done, dbz, quotient, remainder);
    end
    pulses = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_no_done: %0d active cycles, want 0", pulses);
    end
    do_div(16'd9, 16'd3, q, r, z, lat);
    checks++;
    if (q !== 16'd3 || r !== 16'd0 || z !== 1'b0 || lat !== 17) begin
      errors++;
      $display("FAIL after_reset: q=%0d r=%0d z=%b lat=%0d, want 3 0 0 17",
               q, r, z, lat);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, q, r, eq, er;
    logic z, ez;
    int lat;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      unique case (i % 4)
        0: b = W'($urandom_range(1, 15));
        1: b = W'($urandom);
        2: b = W'($urandom_range(16'h8000, 16'hFFFF));
        default: b = (i % 10 == 3) ? '0 : W'($urandom_range(1, 300));
      endcase
      model(a, b, eq, er, ez);
      do_div(a, b, q, r, z, lat);
      checks++;
      if (q !== eq || r !== er || z !== ez || lat !== (ez ? 1 : 17)) begin
        errors++;
        $display("FAIL random %h/%h: q=%h r=%h z=%b lat=%0d, want %h %h %b %0d",
                 a, b, q, r, z, lat, eq, er, ez, ez ? 1 : 17);
      end
    end
  endtask

`ifdef SIGNED_DIV_EN
  task automatic test_signed;
    logic [W-1:0] q, r;
    logic z;
    int lat;
    do_div(16'hFFF9, 16'd2, q, r, z, lat);
    checks++;
    if (q !== 16'hFFFD || r !== 16'hFFFF || lat !== 17) begin
      errors++;
      $display("FAIL signed_neg7_2: q=%h r=%h lat=%0d, want fffd ffff 17",
               q, r, lat);
    end
    do_div(16'h8000, 16'hFFFF, q, r, z, lat);
    checks++;
    if (q !== 16'h8000 || r !== 16'h0000 || z !== 1'b0) begin
      errors++;
      $display("FAIL signed_min_m1: q=%h r=%h z=%b, want 8000 0 0", q, r, z);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_edges;
    test_div_zero;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
`ifdef SIGNED_DIV_EN
    test_signed;
`endif
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
